param_processor_core: RTL

//  Parametrised multi-timestep processor core, successor to the fixed 10-bit design.

---
 rtl/proc_pkg.sv | 85 ++++++++
 rtl/param_alu.sv | 58 +++++
 rtl/param_processor_core.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
// Shared types and field-layout helpers for param_processor_core and its ALU.
//   cls_e     : instruction class (top two bits of IR)
//   fn_e      : function code of the ALU/move group (IR[3:0])
//   tstep_e   : timestep T0..T3
//   kind_e    : decoded instruction kind, drives the timestep sequence
//   bus_sel_e : source of the shared bus
// Field offsets are functions of DATA_W and REG_SEL_W so every user derives
// them the same way.
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam int CLS_W = 2;
    localparam int FN_W  = 4;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_ILL  = 2'b01,
        CLS_ADDI = 2'b10,
        CLS_SUBI = 2'b11
    } cls_e;

    typedef enum logic [3:0] {
        FN_LD  = 4'd0,
        FN_CP  = 4'd1,
        FN_ADD = 4'd2,
        FN_SUB = 4'd3,
        FN_INV = 4'd4,
        FN_FLP = 4'd5,
        FN_AND = 4'd6,
        FN_OR  = 4'd7,
        FN_XOR = 4'd8,
        FN_LSL = 4'd9,
        FN_LSR = 4'd10,
        FN_ASR = 4'd11
    } fn_e;

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;

    typedef enum logic [2:0] {
        K_LD,       // Rx <= raw_data at T1
        K_CP,       // Rx <= Ry at T1
        K_UNARY,    // G <= op(Ry) at T1, Rx <= G at T2
        K_BINARY,   // A <= Rx, G <= A op Ry, Rx <= G
        K_IMM,      // A <= Rx, G <= A +/- IMM, Rx <= G
        K_ILLEGAL   // retire at T1 with no write
    } kind_e;

    typedef enum logic [1:0] {BUS_RAW, BUS_RY, BUS_G, BUS_IMM} bus_sel_e;

    function automatic int rx_lsb(input int data_w, input int reg_sel_w);
        return data_w - CLS_W - reg_sel_w;
    endfunction

    function automatic int ry_lsb(input int data_w, input int reg_sel_w);
        return data_w - CLS_W - 2 * reg_sel_w;
    endfunction

    // IMM occupies everything below Rx.
    function automatic int imm_w(input int data_w, input int reg_sel_w);
        return data_w - CLS_W - reg_sel_w;
    endfunction

    function automatic kind_e decode_kind(input cls_e cls, input logic [FN_W-1:0] fn);
        kind_e k;
        k = K_ILLEGAL;
        case (cls)
            CLS_ADDI, CLS_SUBI: k = K_IMM;
            CLS_ALU: begin
                case (fn)
                    FN_LD:                      k = K_LD;
                    FN_CP:                      k = K_CP;
                    FN_INV, FN_FLP:             k = K_UNARY;
                    FN_ADD, FN_SUB, FN_AND, FN_OR,
                    FN_XOR, FN_LSL, FN_LSR, FN_ASR: k = K_BINARY;
                    default:                    k = K_ILLEGAL;
                endcase
            end
            default: k = K_ILLEGAL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/param_alu.sv
// ----------------------------------------------------------------------------
// param_alu
// Combinational G_next = f(A, bus, class, FN). Serves both the ALU/move group
// and the addi/subi immediate forms (the immediate arrives on the bus).
//   a      in  DATA_W  accumulator A
//   b      in  DATA_W  second operand (shared bus: Ry or zero-extended IMM)
//   cls    in  2       instruction class
//   fn     in  4       function code
//   g_next out DATA_W  value to load into G
// All arithmetic wraps modulo 2^DATA_W; shifts use the full b as the amount.
// ----------------------------------------------------------------------------
module param_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  cls_e              cls,
    input  logic [FN_W-1:0]   fn,
    output logic [DATA_W-1:0] g_next
);

    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    // Out-of-range amounts are made explicit so the result does not depend on
    // how a given tool treats over-wide shift counts.
    logic shift_overrange;
    assign shift_overrange = (b >= SHIFT_LIMIT);

    // NOTE: every branch of a combinational block must assign its outputs;
    // the default up front guarantees that and prevents an inferred latch.
    always_comb begin
        g_next = '0;
        case (cls)
            CLS_ADDI: g_next = a + b;
            CLS_SUBI: g_next = a - b;
            CLS_ALU: begin
                case (fn)
                    FN_ADD:  g_next = a + b;
                    FN_SUB:  g_next = a - b;
                    FN_INV:  g_next = -b;
                    FN_FLP:  g_next = ~b;
                    FN_AND:  g_next = a & b;
                    FN_OR:   g_next = a | b;
                    FN_XOR:  g_next = a ^ b;
                    FN_LSL:  g_next = shift_overrange ? '0 : (a << b);
                    FN_LSR:  g_next = shift_overrange ? '0 : (a >> b);
                    FN_ASR:  g_next = shift_overrange ? {DATA_W{a[DATA_W-1]}}
                                                      : ($signed(a) >>> b);
                    default: g_next = '0;
                endcase
            end
            default: g_next = '0;
        endcase
    end

endmodule

// File: rtl/param_processor_core.sv
// ----------------------------------------------------------------------------
// param_processor_core
// Multi-timestep processor: IR, timestep FSM (T0..T3), register file, A, G.
//   CLOCK_50  in   1          clock, rising edge
//   RST       in   1          synchronous active-high reset
//   raw_data  in   DATA_W     instruction / load data
//   step      in   1          single-cycle advance pulse (pre-synchronised)
//   peek_sel  in   REG_SEL_W  register shown on peek_data
//   bus_out   out  DATA_W     shared bus (combinational)
//   timestep  out  2          current timestep
//   busy      out  1          timestep != T0
//   done      out  1          one-cycle pulse after an instruction retires
//   illegal   out  1          last retired instruction was illegal
//   peek_data out  DATA_W     R[peek_sel]
// A fetch at T0 always needs step; later timesteps advance on step, or on
// every clock when AUTO_STEP=1.
// ----------------------------------------------------------------------------
module param_processor_core
    import proc_pkg::*;
#(
    parameter int  DATA_W    = 10,
    parameter int  REG_CNT   = 4,
    parameter bit  AUTO_STEP = 1'b0,
    localparam int REG_SEL_W = $clog2(REG_CNT)
) (
    input  logic                 CLOCK_50,
    input  logic                 RST,
    input  logic [DATA_W-1:0]    raw_data,
    input  logic                 step,
    input  logic [REG_SEL_W-1:0] peek_sel,
    output logic [DATA_W-1:0]    bus_out,
    output logic [1:0]           timestep,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic [DATA_W-1:0]    peek_data
);

    localparam int RX_LSB = rx_lsb(DATA_W, REG_SEL_W);
    localparam int RY_LSB = ry_lsb(DATA_W, REG_SEL_W);
    localparam int IMM_W  = imm_w(DATA_W, REG_SEL_W);

    tstep_e            ts, ts_next;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_g;
    logic [DATA_W-1:0] regs [REG_CNT];
    logic [DATA_W-1:0] g_next;

    // Instruction fields
    cls_e                 cls;
    logic [REG_SEL_W-1:0] rx;
    logic [REG_SEL_W-1:0] ry;
    logic [FN_W-1:0]      fn;
    logic [IMM_W-1:0]     imm;
    kind_e                kind;

    assign cls  = cls_e'(ir[DATA_W-1 -: CLS_W]);
    assign rx   = ir[RX_LSB +: REG_SEL_W];
    assign ry   = ir[RY_LSB +: REG_SEL_W];
    assign fn   = ir[FN_W-1:0];
    assign imm  = ir[IMM_W-1:0];
    assign kind = decode_kind(cls, fn);

    // Control strobes from the FSM
    logic     advance;
    logic     ld_ir, ld_a, ld_g, wr_rx, retire, flag_ill;
    bus_sel_e bus_sel;

    assign advance = step | AUTO_STEP;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (RST) ts <= T0;
        else     ts <= ts_next;
    end

    // Next state and per-timestep control. The final timestep of every
    // sequence returns to T0, so a step there can never also fetch.
    always_comb begin
        ts_next  = ts;
        ld_ir    = 1'b0;
        ld_a     = 1'b0;
        ld_g     = 1'b0;
        wr_rx    = 1'b0;
        retire   = 1'b0;
        flag_ill = 1'b0;
        bus_sel  = BUS_RAW;
        case (ts)
            T0: begin
                if (step) begin
                    ld_ir   = 1'b1;
                    ts_next = T1;
                end
            end
            T1: begin
                case (kind)
                    K_LD: begin
                        if (advance) begin
                            wr_rx  = 1'b1;
                            retire = 1'b1;
                        end
                    end
                    K_CP: begin
                        bus_sel = BUS_RY;
                        if (advance) begin
                            wr_rx  = 1'b1;
                            retire = 1'b1;
                        end
                    end
                    K_UNARY: begin
                        bus_sel = BUS_RY;
                        if (advance) begin
                            ld_g    = 1'b1;
                            ts_next = T2;
                        end
                    end
                    K_BINARY, K_IMM: begin
                        if (advance) begin
                            ld_a    = 1'b1;
                            ts_next = T2;
                        end
                    end
                    default: begin
                        if (advance) begin
                            retire   = 1'b1;
                            flag_ill = 1'b1;
                        end
                    end
                endcase
            end
            T2: begin
                case (kind)
                    K_UNARY: begin
                        bus_sel = BUS_G;
                        if (advance) begin
                            wr_rx  = 1'b1;
                            retire = 1'b1;
                        end
                    end
                    K_BINARY: begin
                        bus_sel = BUS_RY;
                        if (advance) begin
                            ld_g    = 1'b1;
                            ts_next = T3;
                        end
                    end
                    K_IMM: begin
                        bus_sel = BUS_IMM;
                        if (advance) begin
                            ld_g    = 1'b1;
                            ts_next = T3;
                        end
                    end
                    default: ts_next = T0;  // other kinds never reach T2
                endcase
            end
            T3: begin
                bus_sel = BUS_G;
                if (advance) begin
                    wr_rx  = 1'b1;
                    retire = 1'b1;
                end
            end
            default: ts_next = T0;
        endcase
        if (retire) ts_next = T0;
    end

    // Shared bus. Register writes and the ALU's second operand both take it.
    always_comb begin
        bus_out = raw_data;
        case (bus_sel)
            BUS_RY:  bus_out = regs[ry];
            BUS_G:   bus_out = reg_g;
            BUS_IMM: bus_out = {{(DATA_W-IMM_W){1'b0}}, imm};
            default: bus_out = raw_data;
        endcase
    end

    param_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (reg_a),
        .b      (bus_out),
        .cls    (cls),
        .fn     (fn),
        .g_next (g_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; that is what makes Rx == Ry read the old Rx.
    // NOTE: the register file is cleared on reset, so it is built from flops
    // rather than a RAM macro, which could not be reset in one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            ir      <= '0;
            reg_a   <= '0;
            reg_g   <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else begin
            done <= retire;
            if (ld_ir) begin
                ir      <= raw_data;
                illegal <= 1'b0;
            end
            if (flag_ill) illegal <= 1'b1;
            if (ld_a)     reg_a   <= regs[rx];
            if (ld_g)     reg_g   <= g_next;
            if (wr_rx)    regs[rx] <= bus_out;
        end
    end

    assign timestep  = ts;
    assign busy      = (ts != T0);
    assign peek_data = regs[peek_sel];

endmodule
